// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD-to-binary operand converter.
package bcd_pkg;

  localparam int BCD_W          = 4;
  localparam int BCD_FIX_THRESH = 8;
  localparam int BCD_FIX        = 3;
  localparam int BCD_MAX_DIGIT  = 9;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

endpackage

// File: rtl/sub_3_digit.sv
// Reverse double-dabble correction cell: undoes the display path's add-3 step.
module sub_3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  output logic [BCD_W-1:0] s
);

  // A digit that reached 8+ after the right shift carried a half-ten; pull it back by 3.
  always_comb begin
    s = (a >= BCD_W'(BCD_FIX_THRESH)) ? a - BCD_W'(BCD_FIX) : a;
  end

endmodule

// File: rtl/bcd_to_signed_bin.sv
// Iterative sign+BCD to two's-complement converter; one shift step per clock,
// saturating result with overflow and bad-digit flags.
module bcd_to_signed_bin
  import bcd_pkg::*;
#(
  parameter int NDIG  = 3,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sign_in,
  input  logic [4*NDIG-1:0]     bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      bin_out,
  output logic                  ovf,
  output logic                  bad_digit
);

  localparam int MW   = BCD_W * NDIG;
  localparam int ITER = MW;
  localparam int CW   = $clog2(ITER + 1);

  // Range limits carried one bit wider than the magnitude so 2^(WIDTH-1) always fits.
  localparam logic [MW:0] MAX_POS = (MW+1)'((2 ** (WIDTH - 1)) - 1);
  localparam logic [MW:0] MAX_NEG = MAX_POS + (MW+1)'(1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [MW-1:0]     bcd_q, bcd_d;
  logic [MW-1:0]     mag_q, mag_d;
  logic              bad_flag_q, bad_flag_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic              ovf_q, ovf_d;
  logic              bad_digit_q, bad_digit_d;

  logic [MW-1:0]     bcd_sh;
  logic [MW-1:0]     bcd_fix;
  logic              in_bad;
  logic [MW:0]       mag_ext;
  logic [WIDTH-1:0]  res_bin;
  logic              res_ovf;

  assign bcd_sh = bcd_q >> 1;

  for (genvar g = 0; g < NDIG; g++) begin : g_fix
    sub_3_digit u_fix (
      .a (bcd_sh[g*BCD_W +: BCD_W]),
      .s (bcd_fix[g*BCD_W +: BCD_W])
    );
  end

  // Flag any incoming digit outside 0..9 so the shift phase can be skipped.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX_DIGIT)) in_bad = 1'b1;
    end
  end

  // Signed result with saturation; a bad-digit request always reports zero.
  always_comb begin
    mag_ext = {1'b0, mag_q};
    res_bin = '0;
    res_ovf = 1'b0;
    if (!bad_flag_q) begin
      if (!sign_q) begin
        if (mag_ext <= MAX_POS) begin
          res_bin = WIDTH'(mag_ext);
        end else begin
          res_bin = WIDTH'(MAX_POS);
          res_ovf = 1'b1;
        end
      end else begin
        if (mag_ext <= MAX_NEG) begin
          res_bin = '0 - WIDTH'(mag_ext);
        end else begin
          res_bin = WIDTH'(MAX_NEG);
          res_ovf = 1'b1;
        end
      end
    end
  end

  // Next-state and next-output logic for IDLE -> SHIFT -> FINISH -> IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    bcd_d       = bcd_q;
    mag_d       = mag_q;
    bad_flag_d  = bad_flag_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bin_d       = bin_q;
    ovf_d       = ovf_q;
    bad_digit_d = bad_digit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d     = sign_in;
          bcd_d      = bcd_in;
          mag_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          bad_flag_d = in_bad;
          state_d    = in_bad ? FINISH : SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_fix;
        mag_d = {bcd_q[0], mag_q[MW-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = FINISH;
      end
      FINISH: begin
        bin_d       = res_bin;
        ovf_d       = res_ovf;
        bad_digit_d = bad_flag_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any conversion without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      bcd_q       <= '0;
      mag_q       <= '0;
      bad_flag_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bin_q       <= '0;
      ovf_q       <= 1'b0;
      bad_digit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      bcd_q       <= bcd_d;
      mag_q       <= mag_d;
      bad_flag_q  <= bad_flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bin_q       <= bin_d;
      ovf_q       <= ovf_d;
      bad_digit_q <= bad_digit_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bin_out   = bin_q;
  assign ovf       = ovf_q;
  assign bad_digit = bad_digit_q;

endmodule

// File: tb/tb_bcd_to_signed_bin.sv
// Self-checking bench for bcd_to_signed_bin (NDIG=3, WIDTH=8).
module tb_bcd_to_signed_bin;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign_in;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [7:0]  bin_out;
  logic        ovf;
  logic        bad_digit;

  int ntotal = 0;
  int nbad   = 0;

  bcd_to_signed_bin #(.NDIG(3), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign_in   (sign_in),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .bin_out   (bin_out),
    .ovf       (ovf),
    .bad_digit (bad_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal value of the digits, then range-limit in plain integers.
  function automatic void ref_model(input logic s, input logic [11:0] b,
                                    output logic [7:0] eb, output logic eo, output logic ed);
    int d2, d1, d0, m, v;
    d2 = int'(b[11:8]); d1 = int'(b[7:4]); d0 = int'(b[3:0]);
    eb = 8'h00; eo = 1'b0; ed = 1'b0;
    if (d2 > 9 || d1 > 9 || d0 > 9) begin
      ed = 1'b1;
    end else begin
      m = d2 * 100 + d1 * 10 + d0;
      if (!s) begin
        if (m > 127) begin v = 127; eo = 1'b1; end else v = m;
      end else begin
        if (m > 128) begin v = -128; eo = 1'b1; end else v = -m;
      end
      eb = 8'(v);
    end
  endfunction

  // Drives one request (called #1 after an edge, DUT idle) and waits for done.
  // lat = edges from E0 to the done sample, -1 if it never came.
  task automatic convert(input logic s, input logic [11:0] b, output int lat,
                         output logic [7:0] bo, output logic o, output logic bd,
                         output logic busy_ok, output logic zero_ok);
    start = 1'b1; sign_in = s; bcd_in = b;
    @(posedge clk); #1;
    start = 1'b0; sign_in = 1'($urandom); bcd_in = 12'($urandom);
    busy_ok = (busy === 1'b1) && (done === 1'b0);
    zero_ok = 1'b1;
    lat = -1; bo = 'x; o = 'x; bd = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k; bo = bin_out; o = ovf; bd = bad_digit;
        if (busy !== 1'b0) busy_ok = 1'b0;
        if (bd !== 1'b1 && dut.bcd_q !== 12'h000) zero_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sign_in = 1'b0; bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    ntotal++;
    if ({busy, done, bin_out, ovf, bad_digit} !== 12'h000) begin
      nbad++;
      $display("FAIL reset_outputs got busy=%b done=%b bin=%h ovf=%b bad=%b want all 0",
               busy, done, bin_out, ovf, bad_digit);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    logic        vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] vb [6] = '{12'h127, 12'h128, 12'h000, 12'h200, 12'h999, 12'h042};
    logic [7:0]  eb [6] = '{8'h7F, 8'h80, 8'h00, 8'h7F, 8'h80, 8'h2A};
    logic        eo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat; logic [7:0] bo; logic o, bd, bok, zok;
    for (int i = 0; i < 6; i++) begin
      convert(vs[i], vb[i], lat, bo, o, bd, bok, zok);
      ntotal++;
      if (lat !== 13 || bo !== eb[i] || o !== eo[i] || bd !== 1'b0) begin
        nbad++;
        $display("FAIL vector s=%b bcd=%h got lat=%0d bin=%h ovf=%b bad=%b want lat=13 bin=%h ovf=%b bad=0",
                 vs[i], vb[i], lat, bo, o, bd, eb[i], eo[i]);
      end
      ntotal++;
      if (!bok) begin
        nbad++;
        $display("FAIL vector_busy bcd=%h busy profile wrong, want 1 until done", vb[i]);
      end
    end
  endtask

  task automatic test_bad_digit;
    int lat; logic [7:0] bo; logic o, bd, bok, zok;
    logic [11:0] b;
    convert(1'b0, 12'h1A5, lat, bo, o, bd, bok, zok);
    ntotal++;
    if (lat !== 1 || bo !== 8'h00 || o !== 1'b0 || bd !== 1'b1 || !bok) begin
      nbad++;
      $display("FAIL bad_1A5 got lat=%0d bin=%h ovf=%b bad=%b busy_ok=%b want lat=1 bin=00 ovf=0 bad=1 busy_ok=1",
               lat, bo, o, bd, bok);
    end
    for (int i = 0; i < 20; i++) begin
      b = 12'($urandom);
      b[4*(i%3) +: 4] = 4'($urandom_range(10, 15));
      convert(1'($urandom), b, lat, bo, o, bd, bok, zok);
      ntotal++;
      if (lat !== 1 || bo !== 8'h00 || o !== 1'b0 || bd !== 1'b1) begin
        nbad++;
        $display("FAIL bad_rand bcd=%h got lat=%0d bin=%h ovf=%b bad=%b want lat=1 bin=00 ovf=0 bad=1",
                 b, lat, bo, o, bd);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int ndone = 0, first_k = -1;
    logic [7:0] first_bin = 'x;
    start = 1'b1; sign_in = 1'b0; bcd_in = 12'h042;
    @(posedge clk); #1;                 // E0
    start = 1'b0;
    repeat (4) @(posedge clk);          // E1..E4
    #1;
    start = 1'b1; sign_in = 1'b1; bcd_in = 12'h999;
    @(posedge clk); #1;                 // E5
    start = 1'b0;
    for (int k = 6; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        if (first_k < 0) begin first_k = k; first_bin = bin_out; end
      end
    end
    ntotal++;
    if (ndone !== 1 || first_k !== 13 || first_bin !== 8'h2A) begin
      nbad++;
      $display("FAIL start_while_busy got dones=%0d at=%0d bin=%h want dones=1 at=13 bin=2a",
               ndone, first_k, first_bin);
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    int dk [2] = '{-1, -1};
    logic [7:0] db [2] = '{8'hxx, 8'hxx};
    start = 1'b1; sign_in = 1'b0; bcd_in = 12'h042;
    @(posedge clk); #1;                 // E0; start stays high throughout
    bcd_in = 12'h100;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (ndone < 2) begin dk[ndone] = k; db[ndone] = bin_out; end
        ndone++;
        if (ndone == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    ntotal++;
    if (ndone !== 2 || dk[0] !== 13 || db[0] !== 8'h2A) begin
      nbad++;
      $display("FAIL b2b_first got dones=%0d at=%0d bin=%h want dones=2 at=13 bin=2a",
               ndone, dk[0], db[0]);
    end
    ntotal++;
    if (dk[1] !== 27 || db[1] !== 8'h64) begin
      nbad++;
      $display("FAIL b2b_second got at=%0d bin=%h want at=27 bin=64", dk[1], db[1]);
    end
  endtask

  task automatic test_reset_mid;
    int lat, ndone = 0; logic [7:0] bo; logic o, bd, bok, zok;
    convert(1'b0, 12'h055, lat, bo, o, bd, bok, zok);
    ntotal++;
    if (bo !== 8'h37) begin
      nbad++;
      $display("FAIL pre_reset_conv got bin=%h want 37", bo);
    end
    start = 1'b1; sign_in = 1'b1; bcd_in = 12'h077;
    @(posedge clk); #1;                 // E0
    start = 1'b0;
    repeat (5) @(posedge clk);          // E1..E5
    #1;
    rst = 1'b1;                         // lands before E6
    #1;
    ntotal++;
    if ({busy, done, bin_out, ovf, bad_digit} !== 12'h000) begin
      nbad++;
      $display("FAIL reset_mid got busy=%b done=%b bin=%h ovf=%b bad=%b want all 0",
               busy, done, bin_out, ovf, bad_digit);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    ntotal++;
    if (ndone !== 0) begin
      nbad++;
      $display("FAIL reset_mid_no_done got dones=%0d want 0", ndone);
    end
    convert(1'b0, 12'h099, lat, bo, o, bd, bok, zok);
    ntotal++;
    if (lat !== 13 || bo !== 8'h63 || o !== 1'b0) begin
      nbad++;
      $display("FAIL after_reset got lat=%0d bin=%h ovf=%b want lat=13 bin=63 ovf=0", lat, bo, o);
    end
  endtask

  task automatic test_sweep;
    int lat; logic [7:0] bo, eb; logic o, bd, bok, zok, eo, ed;
    logic [11:0] b;
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 1000; n++) begin
        b = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
        ref_model(1'(s), b, eb, eo, ed);
        convert(1'(s), b, lat, bo, o, bd, bok, zok);
        ntotal++;
        if (lat !== 13 || bo !== eb || o !== eo || bd !== ed) begin
          nbad++;
          $display("FAIL sweep s=%0d bcd=%h got lat=%0d bin=%h ovf=%b bad=%b want lat=13 bin=%h ovf=%b bad=%b",
                   s, b, lat, bo, o, bd, eb, eo, ed);
        end
        ntotal++;
        if (!zok) begin
          nbad++;
          $display("FAIL sweep_bcd_zero s=%0d bcd=%h residual bcd_reg=%h want 000", s, b, dut.bcd_q);
        end
      end
    end
  endtask

  task automatic test_random;
    int lat, elat; logic [7:0] bo, eb; logic o, bd, bok, zok, eo, ed, s;
    logic [11:0] b;
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom);
      b = 12'($urandom);
      ref_model(s, b, eb, eo, ed);
      elat = ed ? 1 : 13;
      convert(s, b, lat, bo, o, bd, bok, zok);
      ntotal++;
      if (lat !== elat || bo !== eb || o !== eo || bd !== ed || !bok) begin
        nbad++;
        $display("FAIL random s=%b bcd=%h got lat=%0d bin=%h ovf=%b bad=%b busy_ok=%b want lat=%0d bin=%h ovf=%b bad=%b",
                 s, b, lat, bo, o, bd, bok, elat, eb, eo, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_bad_digit();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

endmodule
